// File: rtl/alu_seq_ctrl_pkg.sv
// Shared types and sizing helpers for the nibble-serial ALU sequencer.
// The sequencer feeds one 4-bit combinational ALU slice, one nibble per cycle.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  // Width of the nibble index, kept at least 1 bit so a single-nibble build still has a register.
  function automatic int idx_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request/response handshake bundle between the datapath control and the ALU sequencer.
// The master side issues operations; the slave side (the sequencer) answers them.
interface alu_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  localparam int NIB = WIDTH / 4;

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [3:0]       req_s;
  logic             req_m;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_f;
  logic [NIB-1:0]   rsp_hi;
  logic             rsp_zero;
  logic             busy;

  modport master (
    output req_valid, req_a, req_b, req_s, req_m, rsp_ready,
    input  req_ready, rsp_valid, rsp_f, rsp_hi, rsp_zero, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_s, req_m, rsp_ready,
    output req_ready, rsp_valid, rsp_f, rsp_hi, rsp_zero, busy
  );

endinterface

// File: rtl/alu.sv
// 4-bit combinational ALU slice: logic ops (m=1) or 5-bit wrapping arithmetic (m=0).
// cmp flags an all-zero f[3:0].
module alu (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  output logic [4:0] f,
  output logic       cmp
);

  always_comb begin
    f = 5'd0;
    if (m) begin
      unique case (s)
        4'b0000: f = {1'b0, ~a};
        4'b0001: f = {1'b0, ~(a | b)};
        4'b0010: f = {1'b0, ~a & b};
        4'b0011: f = 5'd0;
        4'b0100: f = {1'b0, ~(a & b)};
        4'b0101: f = {1'b0, ~b};
        4'b0110: f = {1'b0, ~(a ^ b)};
        4'b0111: f = {1'b0, a & ~b};
        4'b1000: f = {1'b0, ~a | b};
        4'b1001: f = {1'b0, a ^ b};
        4'b1010: f = {1'b0, b};
        4'b1011: f = {1'b0, a & b};
        4'b1100: f = 5'd0;
        4'b1101: f = {1'b0, a | ~b};
        4'b1110: f = {1'b0, a | b};
        default: f = {1'b0, a};
      endcase
    end else begin
      // f[4] carries the borrow/carry out of the 4-bit result
      unique case (s)
        4'b0000: f = {1'b0, a} - 5'd1;
        4'b0001: f = {1'b0, a} + {1'b0, b};
        4'b0010: f = {1'b0, a} - {1'b0, b};
        4'b0011: f = {1'b0, a} + 5'd1;
        4'b0100: f = {1'b0, a} + {1'b0, a};
        default: f = {1'b0, a};
      endcase
    end
  end

  assign cmp = (f[3:0] == 4'd0);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Nibble-serial initiator for a 4-bit ALU slice: accepts a WIDTH-bit op, runs NIB passes
// LSB nibble first, then holds the assembled result until the response handshake.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_seq_ctrl_if.slave        bus,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [3:0]           alu_s,
  output logic                 alu_m,
  input  logic [4:0]           alu_f,
  input  logic                 alu_cmp
);

  localparam int NIB = WIDTH / NIB_W;
  localparam int IW  = idx_width(NIB);

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic [NIB-1:0]   hi_q, hi_d;
  logic             zero_q, zero_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    m_d     = m_q;
    f_d     = f_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          s_d     = bus.req_s;
          m_d     = bus.req_m;
          f_d     = '0;
          hi_d    = '0;
          zero_d  = 1'b1;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        f_d[NIB_W*int'(idx_q) +: NIB_W] = alu_f[3:0];
        hi_d[idx_q]                     = alu_f[4];
        zero_d                          = zero_q & alu_cmp;
        if (idx_q == IW'(NIB - 1)) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      f_q     <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      m_q     <= m_d;
      f_q     <= f_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
    end
  end

  // ALU inputs come only from captured operands, never from the request port.
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    alu_s = '0;
    alu_m = 1'b0;
    if (state_q == RUN) begin
      alu_a = a_q[NIB_W*int'(idx_q) +: NIB_W];
      alu_b = b_q[NIB_W*int'(idx_q) +: NIB_W];
      alu_s = s_q;
      alu_m = m_q;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.busy      = (state_q == RUN) || (state_q == DONE);
  assign bus.rsp_f     = f_q;
  assign bus.rsp_hi    = hi_q;
  assign bus.rsp_zero  = zero_q;

endmodule
